mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single InstAndDataMemory port between two requesters: port 0 = CPU datapath (fetch/load/store), port 1 = loader/debug DMA.
//  Sits between requester address/data muxes and the memory; CPU control FSM waits on p0_ack instead of assuming fixed-latency access.
//  One transaction in flight; requests are latched so memory inputs are stable for the whole access.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  MEM_LAT   1   cycles mem_read held before mem_rdata is sampled (legal >= 1)
//  FIXED_PRI 0   0 = round-robin on contention; 1 = port 0 always wins
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  p0_req     in   1       port 0 request; held with we/addr/wdata stable until p0_ack
//  p0_we      in   1       port 0: 1 = write, 0 = read
//  p0_addr    in   ADDR_W  port 0 byte address
//  p0_wdata   in   DATA_W  port 0 write data
//  p0_ack     out  1       port 0 one-cycle completion pulse
//  p0_rdata   out  DATA_W  port 0 read data, valid when p0_ack=1, held until next p0 read completes
//  p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rdata   same as port 0, for port 1
//  mem_read   out  1       memory read enable
//  mem_write  out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address (latched)
//  mem_wdata  out  DATA_W  memory write data (latched)
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 when state != IDLE
//  grant_id   out  1       port owning current/last transaction
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; last_grant=1 (so port 0 wins first contention); in-flight access aborted, mem_write drops immediately.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. No other states.
//  IDLE: if any req, pick winner, latch its we/addr/wdata into mem_* regs, set grant_id, go ACCESS; else stay.
//  Winner: single req -> that port. Both: FIXED_PRI=1 -> port 0; FIXED_PRI=0 -> port != last_grant. last_grant updates on entering ACCESS.
//  ACCESS: cnt counts 0..MEM_LAT-1. Write: mem_write=1 only at cnt==0 (exactly one write strobe). Read: mem_read=1 all MEM_LAT cycles; at cnt==MEM_LAT-1 capture mem_rdata into winner's rdata reg. Go RESP after cnt==MEM_LAT-1.
//  RESP: winner's ack=1 for exactly one cycle; mem_read=mem_write=0; go IDLE. Loser's ack never asserted.
//  Latency (uncontended): req seen at edge T -> ack high cycle T+MEM_LAT+1; min 3 cycles req-to-next-grant per port.
//  Requester drops or replaces req on the edge where it sees ack=1; req still high in the IDLE cycle after RESP is a NEW request.
//  mem_addr/mem_wdata hold last latched values when idle (no glitching).
//  Req deasserted mid-transaction: ignored; transaction completes and acks anyway.
//  Round-robin bound: under continuous contention grants alternate 0,1,0,1; no port waits > 1 transaction.
//  Reads of port 1 never disturb p0_rdata and vice versa.
// TESTING
//  1 Reset: reset=0 mid-ACCESS of write -> mem_write, acks, busy go 0 same cycle; after release state IDLE, first contention grants port 0.
//  2 P0 read, MEM_LAT=1: addr 0x0000_0010, mem returns 0x1234_5678 -> mem_read 1 cycle, p0_ack 2 cycles after req edge, p0_rdata=0x12345678.
//  3 P1 write, MEM_LAT=3: addr 0x40, wdata 0xDEAD_BEEF -> mem_write exactly 1 cycle, mem_addr stable 3 cycles, p1_ack at T+4, p0_ack stays 0.
//  4 Contention, FIXED_PRI=0, both req held 4 transactions -> grant_id 0,1,0,1; each port acked twice.
//  5 Contention, FIXED_PRI=1, both req held -> port 0 acked every transaction, p1_ack never until p0_req drops, then p1 granted next IDLE.
//  6 P0 drops req during ACCESS -> transaction still completes, p0_ack pulses once, FSM back to IDLE, no second access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU datapath (port 0)
// and the loader/debug DMA (port 1). One transaction in flight at a time; the
// winner's command is latched so memory inputs stay stable for the access.
//
// Ports:
//   clk, reset                       clock, async active-low reset
//   p0_req/we/addr/wdata, p0_ack/rdata   port 0 requester
//   p1_req/we/addr/wdata, p1_ack/rdata   port 1 requester
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata   memory side
//   busy      high while a transaction is in progress
//   grant_id  port owning the current/last transaction
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_grant_q;
  logic              we_q;
  logic              p0_ack_q, p1_ack_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q, grant_q;

  logic              win_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Winner selection; last_grant resets to 1 so port 0 takes the first contention.
  always_comb begin
    win_d = 1'b0;
    if (p0_req && p1_req) begin
      win_d = (FIXED_PRI != 0) ? 1'b0 : ~last_grant_q;
    end else if (p1_req) begin
      win_d = 1'b1;
    end
    we_d    = win_d ? p1_we    : p0_we;
    addr_d  = win_d ? p1_addr  : p0_addr;
    wdata_d = win_d ? p1_wdata : p0_wdata;
  end

  // IDLE -> ACCESS -> RESP -> IDLE with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      // Strobes default low; a write strobe therefore lasts only the cnt==0 cycle.
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      mem_write_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            state_q      <= S_ACCESS;
            cnt_q        <= '0;
            grant_q      <= win_d;
            last_grant_q <= win_d;
            we_q         <= we_d;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= wdata_d;
            mem_write_q  <= we_d;
            mem_read_q   <= ~we_d;
            busy_q       <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= S_RESP;
            mem_read_q <= 1'b0;
            if (!we_q) begin
              if (grant_q) p1_rdata_q <= mem_rdata;
              else         p0_rdata_q <= mem_rdata;
            end
            // Ack is raised on entry so it is visible for the single RESP cycle.
            p0_ack_q <= ~grant_q;
            p1_ack_q <= grant_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          mem_read_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is round-robin with MEM_LAT=1,
// instance 1 is fixed-priority with MEM_LAT=3. Each has its own memory model
// and scoreboard queue of expected acks in grant order.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic        p0_req [2];
  logic        p0_we  [2];
  logic [31:0] p0_addr[2];
  logic [31:0] p0_wdata[2];
  logic        p0_ack [2];
  logic [31:0] p0_rdata[2];
  logic        p1_req [2];
  logic        p1_we  [2];
  logic [31:0] p1_addr[2];
  logic [31:0] p1_wdata[2];
  logic        p1_ack [2];
  logic [31:0] p1_rdata[2];
  logic        mem_read [2];
  logic        mem_write[2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        busy    [2];
  logic        grant_id[2];

  logic [31:0] mem [2][64];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  int total = 0;
  int bad   = 0;
  int ack_cnt[2][2];
  int wr_cyc[2];
  int rd_cyc[2];

  always #5 clk = ~clk;

  // Combinational memory read model, word-indexed by address bits [7:2].
  always_comb begin
    for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][mem_addr[i][7:2]];
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FIXED_PRI(0)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
    .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
    .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
    .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant_id(grant_id[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .FIXED_PRI(1)) u_fix (
    .clk(clk), .reset(reset),
    .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
    .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
    .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
    .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant_id(grant_id[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int i, input logic port, input logic we, input logic [31:0] d);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.rdata = d;
    if (i == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic sb_pop(input int i, input logic port);
    exp_t e;
    int   sz;
    sz = (i == 0) ? sbq0.size() : sbq1.size();
    chk($sformatf("sb_nonempty%0d", i), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
      chk($sformatf("sb_port%0d", i), 32'(port), 32'(e.port));
      if (!e.we)
        chk($sformatf("sb_rdata%0d_p%0d", i, port),
            port ? p1_rdata[i] : p0_rdata[i], e.rdata);
    end
  endtask

  // Advance to the next falling edge and run the memory/ack monitors there.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (mem_write[i] === 1'b1) begin
        mem[i][mem_addr[i][7:2]] = mem_wdata[i];
        wr_cyc[i]++;
      end
      if (mem_read[i] === 1'b1) rd_cyc[i]++;
      if (p0_ack[i] === 1'b1) begin ack_cnt[i][0]++; sb_pop(i, 1'b0); end
      if (p1_ack[i] === 1'b1) begin ack_cnt[i][1]++; sb_pop(i, 1'b1); end
    end
  endtask

  task automatic wait_acks(input int i, input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      step();
      cyc++;
      if (p0_ack[i] === 1'b1) got++;
      if (p1_ack[i] === 1'b1) got++;
    end
    if (got < n) chk($sformatf("ack_timeout%0d", i), 32'(got), 32'(n));
  endtask

  task automatic drop_all();
    for (int i = 0; i < 2; i++) begin
      p0_req[i] = 1'b0; p0_we[i] = 1'b0;
      p1_req[i] = 1'b0; p1_we[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    drop_all();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  int base0, base1, baser;

  initial begin
    for (int i = 0; i < 2; i++) begin
      p0_addr[i] = '0; p0_wdata[i] = '0; p1_addr[i] = '0; p1_wdata[i] = '0;
      wr_cyc[i] = 0; rd_cyc[i] = 0; ack_cnt[i][0] = 0; ack_cnt[i][1] = 0;
      for (int k = 0; k < 64; k++) mem[i][k] = 32'hC0DE_0000 + 32'(k) + 32'(i) * 32'h100;
    end
    mem[0][4] = 32'h1234_5678;
    drop_all();
    reset = 1'b1;
    @(negedge clk);

    // Reset state and async abort of an in-flight write
    do_reset();
    chk("rst_busy",   32'(busy[0]),      0);
    chk("rst_mem_rd", 32'(mem_read[0]),  0);
    chk("rst_mem_wr", 32'(mem_write[1]), 0);
    chk("rst_grant",  32'(grant_id[0]),  0);
    chk("rst_addr",   mem_addr[0],       0);
    chk("rst_rdata",  p1_rdata[1],       0);
    p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 32'h30; p0_wdata[0] = 32'h5555_AAAA;
    step();
    chk("abort_pre_wr",   32'(mem_write[0]), 1);
    chk("abort_pre_busy", 32'(busy[0]),      1);
    #1 reset = 1'b0;
    drop_all();
    #1;
    chk("abort_wr",   32'(mem_write[0]), 0);
    chk("abort_busy", 32'(busy[0]),      0);
    chk("abort_ack",  32'(p0_ack[0]),    0);
    step();
    reset = 1'b1;
    // First contention after reset goes to port 0, then port 1
    p0_req[0] = 1'b1; p0_addr[0] = 32'h20;
    p1_req[0] = 1'b1; p1_addr[0] = 32'h24;
    sb_push(0, 1'b0, 1'b0, mem[0][8]);
    sb_push(0, 1'b1, 1'b0, mem[0][9]);
    wait_acks(0, 2, 20);
    drop_all();
    chk("rd_isolation", p0_rdata[0], mem[0][8]);

    // Port 0 read, MEM_LAT=1
    do_reset();
    baser = rd_cyc[0];
    p0_req[0] = 1'b1; p0_addr[0] = 32'h10;
    sb_push(0, 1'b0, 1'b0, 32'h1234_5678);
    step();
    chk("p0rd_mem_read", 32'(mem_read[0]), 1);
    chk("p0rd_addr",     mem_addr[0],      32'h10);
    chk("p0rd_ack_early",32'(p0_ack[0]),   0);
    step();
    chk("p0rd_ack",      32'(p0_ack[0]),   1);
    chk("p0rd_mem_read_off", 32'(mem_read[0]), 0);
    chk("p0rd_rdata",    p0_rdata[0],      32'h1234_5678);
    drop_all();
    step();
    chk("p0rd_ack_pulse", 32'(p0_ack[0]), 0);
    chk("p0rd_idle",      32'(busy[0]),   0);
    chk("p0rd_rd_cycles", 32'(rd_cyc[0] - baser), 1);

    // Port 1 write, MEM_LAT=3
    do_reset();
    base0 = wr_cyc[1];
    base1 = ack_cnt[1][0];
    p1_req[1] = 1'b1; p1_we[1] = 1'b1; p1_addr[1] = 32'h40; p1_wdata[1] = 32'hDEAD_BEEF;
    sb_push(1, 1'b1, 1'b1, 32'h0);
    step();
    chk("p1wr_strobe", 32'(mem_write[1]), 1);
    chk("p1wr_addr1",  mem_addr[1],       32'h40);
    chk("p1wr_wdata",  mem_wdata[1],      32'hDEAD_BEEF);
    step();
    chk("p1wr_strobe_off", 32'(mem_write[1]), 0);
    chk("p1wr_addr2",      mem_addr[1],       32'h40);
    step();
    chk("p1wr_addr3",      mem_addr[1],       32'h40);
    chk("p1wr_ack_early",  32'(p1_ack[1]),    0);
    step();
    chk("p1wr_ack",        32'(p1_ack[1]),    1);
    chk("p1wr_p0_ack",     32'(p0_ack[1]),    0);
    drop_all();
    chk("p1wr_strobes", 32'(wr_cyc[1] - base0), 1);
    step();
    p1_req[1] = 1'b1; p1_we[1] = 1'b0; p1_addr[1] = 32'h40;
    sb_push(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    wait_acks(1, 1, 20);
    drop_all();
    chk("p1wr_p0_quiet", 32'(ack_cnt[1][0] - base1), 0);

    // Round-robin contention over four transactions
    do_reset();
    base0 = ack_cnt[0][0];
    base1 = ack_cnt[0][1];
    p0_req[0] = 1'b1; p0_addr[0] = 32'h2C;
    p1_req[0] = 1'b1; p1_addr[0] = 32'h34;
    for (int t = 0; t < 4; t++)
      sb_push(0, 1'(t % 2), 1'b0, (t % 2 == 0) ? mem[0][11] : mem[0][13]);
    wait_acks(0, 4, 40);
    drop_all();
    chk("rr_p0_acks", 32'(ack_cnt[0][0] - base0), 2);
    chk("rr_p1_acks", 32'(ack_cnt[0][1] - base1), 2);
    chk("rr_last_grant", 32'(grant_id[0]), 1);

    // Fixed priority: port 1 starves until port 0 drops
    do_reset();
    base0 = ack_cnt[1][0];
    base1 = ack_cnt[1][1];
    p0_req[1] = 1'b1; p0_addr[1] = 32'h50;
    p1_req[1] = 1'b1; p1_addr[1] = 32'h54;
    for (int t = 0; t < 3; t++) sb_push(1, 1'b0, 1'b0, mem[1][20]);
    wait_acks(1, 3, 60);
    p0_req[1] = 1'b0;
    chk("fp_p1_starved", 32'(ack_cnt[1][1] - base1), 0);
    sb_push(1, 1'b1, 1'b0, mem[1][21]);
    wait_acks(1, 1, 20);
    drop_all();
    chk("fp_p0_acks", 32'(ack_cnt[1][0] - base0), 3);
    chk("fp_p1_acks", 32'(ack_cnt[1][1] - base1), 1);
    chk("fp_grant",   32'(grant_id[1]), 1);

    // Request dropped mid-access still completes exactly once
    do_reset();
    base0 = ack_cnt[0][0];
    baser = rd_cyc[0];
    p0_req[0] = 1'b1; p0_addr[0] = 32'h28;
    sb_push(0, 1'b0, 1'b0, mem[0][10]);
    step();
    p0_req[0] = 1'b0;
    wait_acks(0, 1, 10);
    repeat (4) step();
    chk("drop_acks",  32'(ack_cnt[0][0] - base0), 1);
    chk("drop_reads", 32'(rd_cyc[0] - baser),     1);
    chk("drop_idle",  32'(busy[0]),               0);

    chk("sb_drain0", 32'(sbq0.size()), 0);
    chk("sb_drain1", 32'(sbq1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
